display_scan: RTL and testbench

- Time-multiplexing scanner for the 8-digit 7-segment display.
- Cycles a digit index through the enabled digits at a programmable dwell rate.
- Drives the 3-bit digit index into the digit-select stage, which picks that digit's 5-bit code out of the packed 40-bit digit word.
- Also drives the active-low anode enables, with a blanking gap at each digit change to suppress ghosting.

---
 rtl/display_scan.sv | 113 +++++++++++
 tb/tb_display_scan.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Time-multiplexing scanner for an 8-digit 7-segment display.
// It walks num through the enabled digits and drives active-low anodes, blanking them at the start of each dwell.
module display_scan #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] dig_mask,
    output logic [2:0] num,
    output logic [7:0] an,
    output logic       frame_done
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       num_reg, num_next;
    logic [7:0]       an_reg, an_next;
    logic             frame_reg, frame_next;

    // Masks rotated so that bit 0 is the first candidate of each search.
    logic [7:0] rot_entry, rot_adv;
    logic [2:0] off_entry, off_adv;
    logic [2:0] entry_num, adv_num;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_entry[gi] = dig_mask[num_reg + 3'(gi)];
            assign rot_adv[gi]   = dig_mask[num_reg + 3'(gi + 1)];
        end
    endgenerate

    always_comb begin
        off_entry = 3'd0;
        off_adv   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_entry[i]) off_entry = 3'(i);
            if (rot_adv[i])   off_adv   = 3'(i);
        end
        entry_num = num_reg + off_entry;
        adv_num   = num_reg + off_adv + 3'd1;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        num_next   = num_reg;
        frame_next = 1'b0;
        an_next    = 8'hFF;
        if (!en || dig_mask == 8'h00) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    num_next   = entry_num;
                end
                BLANK: begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = SHOW;
                        if (dig_mask[num_reg]) an_next = ~(8'b1 << num_reg);
                    end
                end
                SHOW: begin
                    if (cnt_reg == DWELL_LAST) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                        num_next   = adv_num;
                        frame_next = (adv_num <= num_reg);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        // Once the lit digit is masked off it stays dark until the advance.
                        if (dig_mask[num_reg]) an_next = an_reg;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            num_reg   <= 3'd0;
            an_reg    <= 8'hFF;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            num_reg   <= num_next;
            an_reg    <= an_next;
            frame_reg <= frame_next;
        end
    end

    assign num        = num_reg;
    assign an         = an_reg;
    assign frame_done = frame_reg;
endmodule

// File: tb/tb_display_scan.sv
// Randomised bench for display_scan against a dwell-position reference model.
// Outputs are checked every cycle, one #1 after the rising edge.
module tb_display_scan;
    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] dig_mask;
    logic [2:0] num;
    logic [7:0] an;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model: scanning flag, position inside the dwell, digit, lit flag.
    bit m_active;
    int m_pos;
    int m_num;
    bit m_fd;
    bit m_lit;

    display_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dig_mask   (dig_mask),
        .num        (num),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int search(input int start, input int first_k, input logic [7:0] mask);
        int res = start;
        bit found = 0;
        for (int k = first_k; k < first_k + 8; k++) begin
            if (!found && mask[(start + k) % 8]) begin
                res = (start + k) % 8;
                found = 1;
            end
        end
        return res;
    endfunction

    task automatic model_edge();
        int old;
        if (!rst_n) begin
            m_num = 0; m_active = 0; m_pos = 0; m_fd = 0; m_lit = 0;
        end else if (!en || dig_mask == 8'h00) begin
            m_active = 0; m_pos = 0; m_fd = 0; m_lit = 0;
        end else if (!m_active) begin
            m_active = 1; m_pos = 0; m_fd = 0; m_lit = 0;
            m_num = search(m_num, 0, dig_mask);
        end else if (m_pos == CLK_DIV - 1) begin
            old = m_num;
            m_num = search(m_num, 1, dig_mask);
            m_pos = 0; m_lit = 0;
            m_fd = (m_num <= old);
        end else begin
            m_pos++;
            m_fd = 0;
            if (m_pos == BLANK_CYCLES) m_lit = dig_mask[m_num];
            else if (m_pos > BLANK_CYCLES) m_lit = m_lit && dig_mask[m_num];
        end
    endtask

    task automatic cycle(input string tag);
        logic [7:0] exp_an;
        @(posedge clk);
        model_edge();
        #1;
        exp_an = 8'hFF;
        if (m_active && m_pos >= BLANK_CYCLES && m_lit) exp_an[m_num] = 1'b0;
        check({tag, ".num"}, 32'(num), 32'(m_num));
        check({tag, ".an"}, 32'(an), 32'(exp_an));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
        $display("%s: rst_n=%b en=%b mask=%02h -> num=%0d an=%02h fd=%b", tag, rst_n, en, dig_mask, num, an, frame_done);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Advance until the model shows digit d in its first lit cycle (bounded).
    task automatic wait_lit(input string tag, input int d);
        int guard = 0;
        while (!(m_active && m_num == d && m_pos == BLANK_CYCLES) && guard < 64) begin
            cycle(tag);
            guard++;
        end
        check({tag, ".reached"}, 32'(guard < 64), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dig_mask = 8'h00;
        m_active = 0; m_pos = 0; m_num = 0; m_fd = 0; m_lit = 0;
        run("reset", 3);
        rst_n = 1'b1;
        run("idle", 4);

        en = 1'b1; dig_mask = 8'hFF;
        run("all_digits", 36);

        dig_mask = 8'b1000_0101;
        run("sparse", 28);

        dig_mask = 8'h10;
        run("single", 16);

        dig_mask = 8'hFF;
        wait_lit("to_d3", 3);
        cycle("d3_lit");
        en = 1'b0;
        run("en_low", 3);
        en = 1'b1;
        run("re_en", 10);

        wait_lit("to_d5", 5);
        dig_mask = 8'hDF;
        run("mask5_off", 4);
        dig_mask = 8'hFF;
        run("after5", 4);
        dig_mask = 8'h00;
        run("mask_zero", 2);
        dig_mask = 8'hFF;
        run("resume", 6);

        for (int r = 0; r < 2500; r++) begin
            case ($urandom_range(0, 39))
                0: en = ~en;
                1, 2: dig_mask = 8'(1 << $urandom_range(0, 7));
                3, 4: dig_mask = 8'($urandom);
                5: dig_mask[$urandom_range(0, 7)] = ~dig_mask[$urandom_range(0, 7)];
                6: dig_mask = 8'hFF;
                7: rst_n = 1'b0;
                default: ;
            endcase
            cycle("rand");
            rst_n = 1'b1;
            if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
